// File: rtl/id_ex_if.sv
// id_ex_if: ID-stage inputs, EX-stage register outputs and stall controls of the ID/EX pipeline register.
interface id_ex_if;
    logic [11:0] id_ctrl;
    logic        id_valid;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_funct;
    logic        flush, hold;
    logic [11:0] ex_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]  ex_funct;
    logic        pc_write, if_id_write;
    logic [15:0] stall_cnt;

    modport master (
        output id_ctrl, id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_shamt, id_funct, flush, hold,
        input  ex_ctrl, ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct,
               pc_write, if_id_write, stall_cnt
    );
    modport slave (
        input  id_ctrl, id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_shamt, id_funct, flush, hold,
        output ex_ctrl, ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct,
               pc_write, if_id_write, stall_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating bubble counter.
module id_ex_pipe (
    input  logic   clk,
    input  logic   reset,
    id_ex_if.slave bus
);
    localparam int ALU_SRC = 9, MEM_READ = 6, MEM_WRITE = 5, BR_NE = 4, BR_EQ = 3;

    typedef struct packed {
        logic [11:0] ctrl;
        logic        valid;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
    } ex_t;

    ex_t         ex_q, ex_d, id_s;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        rt_used, load_use;

    // rt is a source unless the instruction uses the immediate as its second operand
    always_comb begin
        rt_used  = !bus.id_ctrl[ALU_SRC] || bus.id_ctrl[MEM_WRITE] || bus.id_ctrl[BR_NE] || bus.id_ctrl[BR_EQ];
        load_use = ex_q.valid && ex_q.ctrl[MEM_READ] && ex_q.rt != 5'd0 && bus.id_valid &&
                   (ex_q.rt == bus.id_rs || (ex_q.rt == bus.id_rt && rt_used));
    end

    assign id_s = '{ctrl: bus.id_valid ? bus.id_ctrl : 12'd0, valid: bus.id_valid, pc4: bus.id_pc4,
                    rd1: bus.id_rd1, rd2: bus.id_rd2, imm: bus.id_imm, rs: bus.id_rs, rt: bus.id_rt,
                    rd: bus.id_rd, shamt: bus.id_shamt, funct: bus.id_funct};

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) ex_d = '0;
        else if (!bus.hold) begin
            ex_d = load_use ? '0 : id_s;
            if (load_use && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_write    = bus.flush || !(load_use || bus.hold);
    assign bus.if_id_write = bus.flush || !(load_use || bus.hold);
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.ex_ctrl     = ex_q.ctrl;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc4      = ex_q.pc4;
    assign bus.ex_rd1      = ex_q.rd1;
    assign bus.ex_rd2      = ex_q.rd2;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_shamt    = ex_q.shamt;
    assign bus.ex_funct    = ex_q.funct;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: table-driven check of the ID/EX register, hazard stall, priority and counter saturation.
module tb_id_ex_pipe;
    localparam logic [11:0] LW = 12'h3C0, ADD = 12'h482, ADDI = 12'h280, SW = 12'h220, PT = 12'h487, BR = 12'h209;

    typedef struct {
        logic        rstn, flush, hold, valid;
        logic [11:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] pc4;
        logic        pcw, evalid;
        logic [11:0] ectrl;
        logic [4:0]  erd;
        logic [31:0] epc4;
        logic [15:0] ecnt;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset;
    int     total = 0, passed = 0;
    vec_t   tbl[$];

    id_ex_if bus();
    id_ex_pipe dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic rstn, flush, hold, valid, input logic [11:0] ctrl,
                                input logic [4:0] rs, rt, rd, input logic [31:0] pc4, input logic pcw, evalid,
                                input logic [11:0] ectrl, input logic [4:0] erd, input logic [31:0] epc4,
                                input logic [15:0] ecnt);
        vec_t v;
        v = '{rstn, flush, hold, valid, ctrl, rs, rt, rd, pc4, pcw, evalid, ectrl, erd, epc4, ecnt};
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        reset = v.rstn; bus.flush = v.flush; bus.hold = v.hold; bus.id_valid = v.valid;
        bus.id_ctrl = v.ctrl; bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd; bus.id_pc4 = v.pc4;
        bus.id_rd1 = v.pc4 ^ 32'h5555_0000; bus.id_rd2 = v.pc4 ^ 32'h0000_AAAA; bus.id_imm = ~v.pc4;
        bus.id_shamt = v.rd; bus.id_funct = 6'h20;
        #1;
        chk({tag, " pc_write"}, 32'(bus.pc_write), 32'(v.pcw));
        chk({tag, " if_id_write"}, 32'(bus.if_id_write), 32'(v.pcw));
        @(posedge clk); #1;
        chk({tag, " ex_valid"}, 32'(bus.ex_valid), 32'(v.evalid));
        chk({tag, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'(v.ectrl));
        chk({tag, " ex_rd"}, 32'(bus.ex_rd), 32'(v.erd));
        chk({tag, " ex_pc4"}, bus.ex_pc4, v.epc4);
        chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(v.ecnt));
    endtask

    initial begin
        tbl.push_back(mk(1,0,0,1,PT,  8,9,10,32'h104, 1,1,PT,  10,32'h104,16'd0));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h108, 1,1,LW,  0, 32'h108,16'd0));
        tbl.push_back(mk(1,0,0,1,ADD, 5,6,7, 32'h10C, 0,0,12'h0,0,32'h0,  16'd1));
        tbl.push_back(mk(1,0,0,1,ADD, 5,6,7, 32'h10C, 1,1,ADD, 7, 32'h10C,16'd1));
        tbl.push_back(mk(1,0,0,1,LW,  2,0,0, 32'h110, 1,1,LW,  0, 32'h110,16'd1));
        tbl.push_back(mk(1,0,0,1,ADD, 0,0,3, 32'h114, 1,1,ADD, 3, 32'h114,16'd1));
        tbl.push_back(mk(1,0,0,1,LW,  1,7,0, 32'h118, 1,1,LW,  0, 32'h118,16'd1));
        tbl.push_back(mk(1,0,0,1,ADDI,3,7,4, 32'h11C, 1,1,ADDI,4, 32'h11C,16'd1));
        tbl.push_back(mk(1,0,0,1,LW,  1,7,0, 32'h120, 1,1,LW,  0, 32'h120,16'd1));
        tbl.push_back(mk(1,0,0,1,SW,  3,7,2, 32'h124, 0,0,12'h0,0,32'h0,  16'd2));
        tbl.push_back(mk(1,0,0,1,SW,  3,7,2, 32'h124, 1,1,SW,  2, 32'h124,16'd2));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h128, 1,1,LW,  0, 32'h128,16'd2));
        tbl.push_back(mk(1,0,1,1,ADD, 5,6,7, 32'h12C, 0,1,LW,  0, 32'h128,16'd2));
        tbl.push_back(mk(1,1,1,1,ADD, 5,6,7, 32'h12C, 1,0,12'h0,0,32'h0,  16'd2));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h130, 1,1,LW,  0, 32'h130,16'd2));
        tbl.push_back(mk(1,1,0,1,ADD, 5,6,7, 32'h134, 1,0,12'h0,0,32'h0,  16'd2));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h138, 1,1,LW,  0, 32'h138,16'd2));
        tbl.push_back(mk(1,0,0,0,ADD, 5,6,9, 32'h13C, 1,0,12'h0,9,32'h13C,16'd2));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h140, 1,1,LW,  0, 32'h140,16'd2));
        tbl.push_back(mk(0,0,0,1,ADD, 5,6,7, 32'h144, 0,0,12'h0,0,32'h0,  16'd0));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h148, 1,1,LW,  0, 32'h148,16'd0));
        tbl.push_back(mk(1,0,0,1,BR,  1,5,0, 32'h14C, 0,0,12'h0,0,32'h0,  16'd1));
        tbl.push_back(mk(1,0,0,1,BR,  1,5,0, 32'h14C, 1,1,BR,  0, 32'h14C,16'd1));
        tbl.push_back(mk(1,0,0,1,LW,  1,5,0, 32'h150, 1,1,LW,  0, 32'h150,16'd1));
        tbl.push_back(mk(1,0,0,1,ADD, 1,5,7, 32'h154, 0,0,12'h0,0,32'h0,  16'd2));
        tbl.push_back(mk(1,0,0,1,ADD, 1,5,7, 32'h154, 1,1,ADD, 7, 32'h154,16'd2));

        reset = 1'b0; bus.flush = 1'($urandom); bus.hold = 1'($urandom); bus.id_valid = 1'($urandom);
        bus.id_ctrl = 12'($urandom); bus.id_pc4 = $urandom; bus.id_rd1 = $urandom; bus.id_rd2 = $urandom;
        bus.id_imm = $urandom; bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom); bus.id_rd = 5'($urandom);
        bus.id_shamt = 5'($urandom); bus.id_funct = 6'($urandom);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.hold = 1'b0;
        #1;
        chk("rst ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst ex_pc4", bus.ex_pc4, 32'd0);
        chk("rst ex_rd1", bus.ex_rd1, 32'd0);
        chk("rst ex_rd2", bus.ex_rd2, 32'd0);
        chk("rst ex_imm", bus.ex_imm, 32'd0);
        chk("rst ex_regs", 32'({bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_funct}), 32'd0);
        chk("rst stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst pc_write", 32'(bus.pc_write), 32'd1);
        chk("rst if_id_write", 32'(bus.if_id_write), 32'd1);

        reset = 1'b1; bus.id_valid = 1'b1; bus.id_ctrl = PT; bus.id_pc4 = 32'h0000_1000;
        bus.id_rd1 = 32'h1111_1111; bus.id_rd2 = 32'h2222_2222; bus.id_imm = 32'hFFFF_FFF0;
        bus.id_rs = 5'd8; bus.id_rt = 5'd9; bus.id_rd = 5'd10; bus.id_shamt = 5'd3; bus.id_funct = 6'h20;
        @(posedge clk); #1;
        chk("pt ex_ctrl", 32'(bus.ex_ctrl), 32'h487);
        chk("pt ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("pt ex_pc4", bus.ex_pc4, 32'h0000_1000);
        chk("pt ex_rd1", bus.ex_rd1, 32'h1111_1111);
        chk("pt ex_rd2", bus.ex_rd2, 32'h2222_2222);
        chk("pt ex_imm", bus.ex_imm, 32'hFFFF_FFF0);
        chk("pt ex_rs", 32'(bus.ex_rs), 32'd8);
        chk("pt ex_rt", 32'(bus.ex_rt), 32'd9);
        chk("pt ex_rd", 32'(bus.ex_rd), 32'd10);
        chk("pt ex_shamt", 32'(bus.ex_shamt), 32'd3);
        chk("pt ex_funct", 32'(bus.ex_funct), 32'h20);

        for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1 release dut.stall_cnt_q;
        run_vec("sat0", mk(1,0,0,1,LW, 1,5,0,32'h200, 1,1,LW, 0,32'h200,16'hFFFE));
        run_vec("sat1", mk(1,0,0,1,ADD,5,6,7,32'h204, 0,0,12'h0,0,32'h0,16'hFFFF));
        run_vec("sat2", mk(1,0,0,1,ADD,5,6,7,32'h204, 1,1,ADD,7,32'h204,16'hFFFF));
        run_vec("sat3", mk(1,0,0,1,LW, 1,5,0,32'h20C, 1,1,LW, 0,32'h20C,16'hFFFF));
        run_vec("sat4", mk(1,0,0,1,ADD,5,6,7,32'h210, 0,0,12'h0,0,32'h0,16'hFFFF));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
